// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared state encoding for the loadable down-counter.
`default_nettype none

package down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/down_counter.sv
// down_counter: loadable down-counter/timer with one-shot or auto-reload
// operation and a registered terminal-count pulse.
`default_nettype none

module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             CLR_N,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] LOAD_VALUE,
  input  logic             EN,
  input  logic             MODE,
  input  logic             STOP,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic             tc;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      tc <= 1'b0;
      case (state)
        RUN: begin
          if (STOP) begin
            state <= IDLE;
          end else if (EN) begin
            if (count > ONE) begin
              count <= count - ONE;
            end else begin
              // Terminal detection at 1 keeps COUNT from ever wrapping below 0.
              tc <= 1'b1;
              if (MODE) begin
                count <= reload;
              end else begin
                count <= '0;
                state <= DONE_ST;
              end
            end
          end
        end
        default: begin
          if (LOAD_VALID) begin
            count  <= LOAD_VALUE;
            reload <= LOAD_VALUE;
            if (LOAD_VALUE == '0) begin
              state <= DONE_ST;
              tc    <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
      endcase
    end
  end

  assign COUNT      = count;
  assign TC         = tc;
  assign BUSY       = (state == RUN);
  assign LOAD_READY = (state != RUN);
  assign DONE       = (state == DONE_ST);

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
// tb_down_counter: vector table, directed corner sequences and randomized
// stimulus against a behavioural model of the down-counter.
`default_nettype none

module tb_down_counter;

  localparam int W = 4;

  logic         CLK, CLR_N, LOAD_VALID, EN, MODE, STOP;
  logic [W-1:0] LOAD_VALUE;
  logic         LOAD_READY, TC, BUSY, DONE;
  logic [W-1:0] COUNT;

  down_counter #(.WIDTH(W)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .LOAD_VALUE(LOAD_VALUE), .EN(EN), .MODE(MODE), .STOP(STOP),
    .COUNT(COUNT), .TC(TC), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain integers and flags.
  int m_count, m_reload;
  bit m_busy, m_done, m_tc;

  typedef struct {
    logic       valid;
    logic [3:0] value;
    logic       en, mode, stop;
    int         cnt;
    logic       tc, busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(logic v, int val, logic e, logic m, logic s,
                               int c, logic t, logic b, logic d);
    vec_t x;
    x.valid = v; x.value = 4'(val); x.en = e; x.mode = m; x.stop = s;
    x.cnt = c; x.tc = t; x.busy = b; x.done = d;
    return x;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_reload = 0; m_busy = 0; m_done = 0; m_tc = 0;
  endtask

  task automatic model_step();
    m_tc = 0;
    if (m_busy) begin
      if (STOP) m_busy = 0;
      else if (EN) begin
        if (m_count > 1) m_count = m_count - 1;
        else begin
          m_tc = 1;
          if (MODE) m_count = m_reload;
          else begin m_count = 0; m_busy = 0; m_done = 1; end
        end
      end
    end else if (LOAD_VALID) begin
      m_count = int'(LOAD_VALUE); m_reload = int'(LOAD_VALUE); m_done = 0;
      if (LOAD_VALUE == 0) begin m_done = 1; m_tc = 1; end
      else m_busy = 1;
    end
  endtask

  task automatic check_model(string tag);
    chk({tag, ".count"}, int'(COUNT), m_count);
    chk({tag, ".tc"},    int'(TC),    int'(m_tc));
    chk({tag, ".busy"},  int'(BUSY),  int'(m_busy));
    chk({tag, ".done"},  int'(DONE),  int'(m_done));
    chk({tag, ".ready"}, int'(LOAD_READY), int'(!m_busy));
  endtask

  // One rising edge; outputs sampled 1ns later.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(logic v, int val, logic e, logic m, logic s);
    LOAD_VALID = v; LOAD_VALUE = 4'(val); EN = e; MODE = m; STOP = s;
  endtask

  task automatic async_reset();
    #2 CLR_N = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    #2 CLR_N = 1'b1;
  endtask

  initial begin
    CLR_N = 1'b0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    #12;
    check_model("reset");
    CLR_N = 1'b1;
    @(posedge CLK); #1;
    check_model("idle");

    // One-shot 3, auto-reload 4 with STOP, enable gaps then STOP at 3.
    vecs.push_back(mkv(1, 3, 1, 0, 0, 3, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 2, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mkv(1, 4, 1, 1, 0, 4, 0, 1, 0));
    for (int k = 0; k < 12; k++)
      vecs.push_back(mkv(0, 0, 1, 1, 0, 4 - ((k + 1) % 4), ((k % 4) == 3), 1, 0));
    vecs.push_back(mkv(0, 0, 1, 1, 1, 4, 0, 0, 0));
    vecs.push_back(mkv(1, 5, 1, 0, 0, 5, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 4, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 4, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 0, 0, 0, 4, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 3, 0, 1, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 3, 0, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].valid, int'(vecs[i].value), vecs[i].en, vecs[i].mode, vecs[i].stop);
      tick();
      chk($sformatf("vec%0d.count", i), int'(COUNT), vecs[i].cnt);
      chk($sformatf("vec%0d.tc", i),    int'(TC),    int'(vecs[i].tc));
      chk($sformatf("vec%0d.busy", i),  int'(BUSY),  int'(vecs[i].busy));
      chk($sformatf("vec%0d.done", i),  int'(DONE),  int'(vecs[i].done));
      chk($sformatf("vec%0d.ready", i), int'(LOAD_READY), int'(!vecs[i].busy));
    end

    // Zero load completes immediately with a single TC.
    drive(1, 0, 0, 1, 0); tick();
    chk("load0.tc", int'(TC), 1); chk("load0.done", int'(DONE), 1);
    drive(0, 0, 0, 1, 0); tick();
    chk("load0.tc_next", int'(TC), 0); check_model("load0");

    // Full-range one-shot.
    drive(1, 15, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0);
    for (int k = 0; k < 15; k++) begin
      tick();
      check_model("load15");
    end
    chk("load15.count", int'(COUNT), 0);
    chk("load15.done", int'(DONE), 1);

    // Load offered while busy is ignored.
    drive(1, 9, 1, 0, 0); tick();
    drive(1, 2, 1, 0, 0); tick();
    chk("busyload.count", int'(COUNT), 8);
    chk("busyload.ready", int'(LOAD_READY), 0);
    drive(0, 0, 0, 0, 1); tick(); check_model("busyload");

    // Reload of 1: TC on every enabled edge.
    drive(1, 1, 1, 1, 0); tick();
    drive(0, 0, 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("reload1.tc", int'(TC), 1);
      chk("reload1.count", int'(COUNT), 1);
    end
    drive(0, 0, 1, 1, 1); tick(); check_model("reload1_stop");

    // Asynchronous reset mid-count at 6, then no counting without a load.
    drive(1, 8, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick(); tick();
    chk("arst.pre_count", int'(COUNT), 6);
    async_reset();
    tick(); check_model("arst_after");
    chk("arst.count_after", int'(COUNT), 0);

    // STOP coincident with terminal event.
    drive(1, 2, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 1); tick();
    chk("stop_tc.tc", int'(TC), 0);
    chk("stop_tc.busy", int'(BUSY), 0);
    chk("stop_tc.count", int'(COUNT), 1);

    // MODE raised just before the terminal edge takes the reload.
    drive(1, 2, 1, 0, 0); tick();
    drive(0, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 1, 0); tick();
    chk("mode_late.tc", int'(TC), 1);
    chk("mode_late.count", int'(COUNT), 2);
    chk("mode_late.busy", int'(BUSY), 1);
    drive(0, 0, 0, 0, 1); tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      drive(($urandom_range(0, 9) < 3), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                                                    : int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 19) == 0));
      tick();
      check_model("rand");
      if ($urandom_range(0, 99) == 0) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/down_counter.md
Name: down_counter

Overview:
Synchronous, loadable down-counter/timer that is the counting-down companion to the team's up-counting ripple counter.
- Accepts a start value over a valid/ready load handshake.
- Decrements once per enabled clock and flags terminal count.
- Either stops (one-shot) or reloads (periodic).
- Used as a delay/period generator next to the ripple counters in the counter examples.

Parameters:
WIDTH, 4, bit width of COUNT, LOAD_VALUE and the internal reload register (WIDTH >= 1)

Ports:
CLK  input  1  clock, all state updates on rising edge
CLR_N  input  1  asynchronous active-low reset
LOAD_VALID  input  1  start value offered
LOAD_READY  output  1  counter can accept a load
LOAD_VALUE  input  WIDTH  start/reload value
EN  input  1  count enable; hold when low
MODE  input  1  0 = one-shot, 1 = auto-reload
STOP  input  1  abort a running count
COUNT  output  WIDTH  current count value
TC  output  1  registered terminal-count pulse
BUSY  output  1  high while counting
DONE  output  1  sticky one-shot completion flag

Behaviour:
- One clock (CLK). Reset is asynchronous and active-low (CLR_N); the polarity and synchronicity are fixed.
- Reset (CLR_N low, async, any time including mid-count):
  - state IDLE; COUNT=0; reload register=0.
  - TC=0, BUSY=0, DONE=0, LOAD_READY=1.
  - Takes effect immediately, without waiting for a clock edge.
- States: IDLE, RUN, DONE_ST.
  - BUSY = (state==RUN).
  - LOAD_READY = (state!=RUN).
  - DONE = (state==DONE_ST).
  - All outputs are registered or decoded from registered state only.
- Load (LOAD_VALID && LOAD_READY at a rising edge):
  - COUNT<=LOAD_VALUE; reload<=LOAD_VALUE.
  - If LOAD_VALUE!=0: next state RUN, TC<=0.
  - If LOAD_VALUE==0: next state DONE_ST, TC<=1 for one cycle. Zero-length count completes immediately, independent of MODE.
  - LOAD_VALID while BUSY is ignored (not accepted, no side effects). The source must hold it until LOAD_READY.
- RUN, evaluated each rising edge in priority order:
  1. STOP=1: state IDLE, COUNT held, TC<=0. STOP overrides EN and the terminal event.
  2. EN=0: hold COUNT, TC<=0.
  3. EN=1 and COUNT>1: COUNT<=COUNT-1, TC<=0.
  4. EN=1 and COUNT==1 (terminal event): TC<=1. MODE is sampled at this edge:
     - MODE=0: COUNT<=0, state DONE_ST.
     - MODE=1: COUNT<=reload, stay RUN.
- Period and pulse rules:
  - Reload period is exactly `reload` enabled cycles; TC is high one cycle per period.
  - With reload==1 in MODE=1: COUNT stays 1 and TC is high on every cycle following an enabled edge.
- TC is high only in the cycle immediately after the edge that produced it; it is never high for two consecutive cycles unless there are consecutive terminal events.
- IDLE / DONE_ST: COUNT held; EN and STOP ignored; TC<=0 unless a zero load occurs.
- A load from DONE_ST clears DONE on the accepting edge.
- Arithmetic: unsigned WIDTH-bit values. COUNT never decrements below 0 (no wrap), because terminal detection is at 1. Max load is 2^WIDTH-1.

Decomposition:
- Package down_counter_pkg holds typedef enum logic [1:0] state_e {IDLE, RUN, DONE_ST}.
- No sub-module. The block is one FSM always_ff with an async-low reset branch plus the COUNT/reload datapath, in a single file.

Test Plan (WIDTH=4 unless noted):
- One-shot: load 3, MODE=0, EN=1 -> COUNT 3,2,1,0 on successive cycles. TC high only the cycle COUNT first reads 0. DONE=1, BUSY=0, LOAD_READY=1 after that.
- Auto-reload: load 4, MODE=1, EN=1 for 12 cycles -> COUNT sequence 4,3,2,1,4,3,2,1,4,3,2,1. TC high exactly 3 times, 4 cycles apart. BUSY stays 1.
- Enable gaps and STOP: load 5, then EN=1,0,0,1, then STOP with COUNT==3 -> COUNT 5,4,4,4,3, then IDLE with COUNT=3 held, TC never asserted, LOAD_READY=1.
- Load edge cases:
  - load 0 -> DONE=1 and a single TC pulse next cycle.
  - load 15 -> full 15-cycle one-shot.
  - LOAD_VALID while BUSY -> COUNT unaffected, LOAD_READY=0.
  - load 1 in MODE=1 -> TC high every cycle with EN=1.
- Async reset: assert CLR_N=0 between clock edges at COUNT=6 during RUN -> COUNT=0, BUSY=0, TC=0, DONE=0, LOAD_READY=1 before the next edge. Counting restarts only after a new load.
- Simultaneous events: STOP=1 on the same edge as a terminal event (COUNT==1, EN=1) -> no TC, state IDLE, COUNT=1. MODE toggled 0->1 just before the terminal edge -> reload taken.
